// File: rtl/hdshk_pkg.sv
// rtl/hdshk_pkg.sv - shared types and defaults for the req/ack receiver
// Contents:
//   DW_DEF          default data word width
//   SYNC_STAGES_DEF default depth of the req synchronizer (minimum 2)
//   state_e         receiver FSM states
package hdshk_pkg;

    localparam int DW_DEF          = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/hdshk_req_ack_rx_if.sv
// rtl/hdshk_req_ack_rx_if.sv - handshake bundle between source, receiver and consumer
// Signals:
//   req_a, data_a        4-phase request and data from the source domain
//   ack_b                4-phase acknowledge back to the source
//   dout, dout_valid     captured word offered downstream
//   dout_ready           downstream accept
//   busy, proto_err      receiver status
// Modports:
//   master  environment side (source + consumer)
//   slave   receiver side
interface hdshk_req_ack_rx_if #(
    parameter int DW = hdshk_pkg::DW_DEF
);
    logic          req_a;
    logic [DW-1:0] data_a;
    logic          ack_b;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          proto_err;

    modport master (
        output req_a, data_a, dout_ready,
        input  ack_b, dout, dout_valid, busy, proto_err
    );

    modport slave (
        input  req_a, data_a, dout_ready,
        output ack_b, dout, dout_valid, busy, proto_err
    );
endinterface

// File: rtl/hdshk_bit_sync.sv
// rtl/hdshk_bit_sync.sv - multi-flop single-bit synchronizer with async active-low clear
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low clear of every stage
//   d_i    asynchronous input bit
//   q_o    synchronized output (last stage only)
module hdshk_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hdshk_req_ack_rx.sv
// rtl/hdshk_req_ack_rx.sv - 4-phase req/ack receiver delivering words on a valid/ready port
// Ports:
//   clk_b  receiver clock, all flops on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    hdshk_req_ack_rx_if slave: req_a/data_a in, ack_b out,
//          dout/dout_valid/dout_ready downstream, busy/proto_err status
module hdshk_req_ack_rx
    import hdshk_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         clk_b,
    input  logic         rst_n,
    hdshk_req_ack_rx_if.slave bus
);

    state_e        state_q, state_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ack_q, ack_d;
    logic          perr_q, perr_d;
    logic          busy_q;
    logic          req_s;

    hdshk_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_b),
        .rst_n (rst_n),
        .d_i   (bus.req_a),
        .q_o   (req_s)
    );

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            perr_q  <= perr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    dout_d  = bus.data_a;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ack_d = 1'b0;
                // The source must keep req high until it sees ack; a drop here
                // is flagged, but the captured word is still delivered.
                if (!req_s) begin
                    perr_d = 1'b1;
                end
                if (bus.dout_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                valid_d = 1'b0;
                if (req_s) begin
                    ack_d = 1'b1;
                end else begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
    end

    assign bus.ack_b      = ack_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.proto_err  = perr_q;

endmodule

// File: tb/tb_hdshk_req_ack_rx.sv
// tb/tb_hdshk_req_ack_rx.sv - self-checking bench for hdshk_req_ack_rx
`timescale 1ns/100ps
module tb_hdshk_req_ack_rx;

    logic clk_b = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_b = ~clk_b;

    hdshk_req_ack_rx_if #(.DW(8)) bus  ();
    hdshk_req_ack_rx_if #(.DW(8)) bus3 ();

    hdshk_req_ack_rx #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk_b (clk_b),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hdshk_req_ack_rx #(.DW(8), .SYNC_STAGES(3)) dut3 (
        .clk_b (clk_b),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int checks   = 0;
    int failures = 0;
    int mon_cnt  = 0;
    int exp_cnt  = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        int         bp;
        logic [7:0] exp_dout;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: samples just before each rising edge, where a
    // valid&ready pair means a transfer on that edge.
    always @(negedge clk_b) begin
        #4;
        if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
            mon_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_word actual=%0h required=none", bus.dout);
            end else begin
                chk("sb_dout", bus.dout, sb.pop_front());
            end
        end
    end

    // sel: 0 = dout_valid high, 1 = ack_b high, 2 = ack_b low
    task automatic wait_cond(input int sel, input string name);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_b);
            case (sel)
                0:       ok = (bus.dout_valid === 1'b1);
                1:       ok = (bus.ack_b === 1'b1);
                default: ok = (bus.ack_b === 1'b0);
            endcase
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic do_word(input vec_t v);
        bus.dout_ready = (v.bp == 0);
        bus.data_a     = v.data;
        sb.push_back(v.exp_dout);
        exp_cnt++;
        bus.req_a = 1'b1;
        wait_cond(0, "wait_valid");
        chk("cap_dout", bus.dout, v.exp_dout);
        chk("cap_ack_low", bus.ack_b, 1'b0);
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk_b);
            chk("bp_valid", bus.dout_valid, 1'b1);
            chk("bp_dout", bus.dout, v.exp_dout);
            chk("bp_ack", bus.ack_b, 1'b0);
        end
        bus.dout_ready = 1'b1;
        @(negedge clk_b);
        chk("xfer_valid_low", bus.dout_valid, 1'b0);
        chk("xfer_ack_high", bus.ack_b, 1'b1);
        bus.req_a = 1'b0;
        @(negedge clk_b);
        @(negedge clk_b);
        chk("ack_hold", bus.ack_b, 1'b1);
        @(negedge clk_b);
        chk("ack_fall", bus.ack_b, 1'b0);
        chk("busy_idle", bus.busy, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, bp: 0,  exp_dout: 8'hA5};
        vecs[1] = '{data: 8'h3C, bp: 10, exp_dout: 8'h3C};
        vecs[2] = '{data: 8'h00, bp: 0,  exp_dout: 8'h00};
        vecs[3] = '{data: 8'hFF, bp: 3,  exp_dout: 8'hFF};
        vecs[4] = '{data: 8'h5A, bp: 1,  exp_dout: 8'h5A};

        bus.req_a  = 0; bus.data_a  = 0; bus.dout_ready  = 0;
        bus3.req_a = 0; bus3.data_a = 0; bus3.dout_ready = 0;
        repeat (3) @(negedge clk_b);
        chk("rst_ack", bus.ack_b, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_perr", bus.proto_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_b);

        // Latency: 2-stage valid after edge 2, 3-stage after edge 3
        bus.data_a = 8'h77; bus3.data_a = 8'h77;
        sb.push_back(8'h77); exp_cnt++;
        bus.req_a = 1'b1; bus3.req_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_b);
            chk($sformatf("lat2_e%0d", k), bus.dout_valid, (k >= 2));
            chk($sformatf("lat3_e%0d", k), bus3.dout_valid, (k >= 3));
        end
        chk("lat3_dout", bus3.dout, 8'h77);
        bus.dout_ready = 1'b1; bus3.dout_ready = 1'b1;
        @(negedge clk_b);
        chk("lat2_ack", bus.ack_b, 1);
        chk("lat3_ack", bus3.ack_b, 1);
        bus.req_a = 1'b0; bus3.req_a = 1'b0;
        repeat (4) @(negedge clk_b);
        chk("lat2_ack_low", bus.ack_b, 0);
        chk("lat3_ack_low", bus3.ack_b, 0);
        chk("lat3_busy", bus3.busy, 0);

        foreach (vecs[i]) do_word(vecs[i]);

        // Back-to-back words with source timing unrelated to clk_b
        bus.dout_ready = 1'b1;
        @(negedge clk_b);
        #0.5;
        for (int w = 1; w <= 4; w++) begin
            bit ok;
            bus.data_a = w[7:0];
            sb.push_back(w[7:0]); exp_cnt++;
            #($urandom_range(3, 30));
            bus.req_a = 1'b1;
            ok = 0;
            for (int p = 0; p < 300 && !ok; p++) begin
                #($urandom_range(3, 30));
                ok = (bus.ack_b === 1'b1);
            end
            chk("b2b_ack_high", ok, 1);
            #($urandom_range(3, 30));
            bus.req_a = 1'b0;
            ok = 0;
            for (int p = 0; p < 300 && !ok; p++) begin
                #($urandom_range(3, 30));
                ok = (bus.ack_b === 1'b0);
            end
            chk("b2b_ack_low", ok, 1);
        end
        repeat (5) @(negedge clk_b);
        chk("b2b_sb_empty", sb.size(), 0);
        chk("b2b_count", mon_cnt, exp_cnt);

        // Protocol error: req dropped while word is held
        bus.dout_ready = 1'b0;
        bus.data_a = 8'hC3;
        sb.push_back(8'hC3); exp_cnt++;
        bus.req_a = 1'b1;
        wait_cond(0, "perr_wait_valid");
        bus.req_a = 1'b0;
        @(negedge clk_b);
        @(negedge clk_b);
        chk("perr_not_yet", bus.proto_err, 0);
        @(negedge clk_b);
        chk("perr_set", bus.proto_err, 1);
        chk("perr_valid_kept", bus.dout_valid, 1);
        chk("perr_busy", bus.busy, 1);
        bus.dout_ready = 1'b1;
        @(negedge clk_b);
        chk("perr_ack", bus.ack_b, 1);
        @(negedge clk_b);
        chk("perr_ack_low", bus.ack_b, 0);
        chk("perr_idle", bus.busy, 0);
        repeat (5) @(negedge clk_b);
        chk("perr_sticky", bus.proto_err, 1);
        chk("perr_delivered", mon_cnt, exp_cnt);

        // Reset while holding a word: word abandoned, outputs clear at once
        bus.dout_ready = 1'b0;
        bus.data_a = 8'h99;
        bus.req_a = 1'b1;
        wait_cond(0, "rst_hold_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("rsth_valid", bus.dout_valid, 0);
        chk("rsth_dout", bus.dout, 0);
        chk("rsth_busy", bus.busy, 0);
        chk("rsth_perr", bus.proto_err, 0);
        chk("rsth_ack", bus.ack_b, 0);
        bus.req_a = 1'b0;
        @(negedge clk_b);
        rst_n = 1'b1;
        @(negedge clk_b);

        // Reset while acknowledging
        bus.dout_ready = 1'b1;
        bus.data_a = 8'h42;
        sb.push_back(8'h42); exp_cnt++;
        bus.req_a = 1'b1;
        wait_cond(1, "rst_ack_wait");
        chk("rsta_busy_pre", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rsta_ack", bus.ack_b, 0);
        chk("rsta_dout", bus.dout, 0);
        chk("rsta_busy", bus.busy, 0);
        chk("rsta_valid", bus.dout_valid, 0);
        bus.req_a = 1'b0;
        @(negedge clk_b);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_b);

        chk("final_sb_empty", sb.size(), 0);
        chk("final_count", mon_cnt, exp_cnt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdshk_req_ack_rx.md
HDSHK_REQ_ACK_RX -- requirements
Module: hdshk_req_ack_rx

Interface
REQ-001 Parameter: DW, default 8, width of the transferred data word.
REQ-002 Parameter: SYNC_STAGES, default 2, minimum 2, number of flops in the req synchronizer.
REQ-003 clk_b  input  1  sole clock; all internal flops are clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_a  input  1  4-phase request from the source clock domain; asynchronous to clk_b.
REQ-006 data_a  input  DW  source data; the source holds it stable from before req_a rises until it observes ack_b high.
REQ-007 ack_b  output  1  4-phase acknowledge to the source; driven directly from a flop.
REQ-008 dout  output  DW  captured data word, registered.
REQ-009 dout_valid  output  1  dout holds an unconsumed word.
REQ-010 dout_ready  input  1  downstream consumer accepts dout.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 proto_err  output  1  sticky flag: source protocol violation detected.

Function
REQ-013 req_a SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (req_s) is used by any logic.
REQ-014 FSM states SHALL be exactly IDLE, HOLD and ACK.
REQ-015 IDLE, req_s=1: capture data_a into dout, set dout_valid=1, go to HOLD, all on the same edge.
REQ-016 IDLE, req_s=0: stay; dout and dout_valid=0 unchanged.
REQ-017 HOLD, dout_ready=1: clear dout_valid, set ack_b=1, go to ACK, all on the same edge.
REQ-018 HOLD, dout_ready=0: stay; dout and dout_valid stable; ack_b=0.
REQ-019 ACK, req_s=0: clear ack_b, go to IDLE.
REQ-020 ACK, req_s=1: stay with ack_b=1.
REQ-021 Latency: with SYNC_STAGES=2, req_a rising before edge 0 SHALL give dout_valid=1 after edge 2, i.e. SYNC_STAGES+1 edges.
REQ-022 dout_ready high before dout_valid SHALL cause no transfer; a transfer occurs only on an edge where dout_valid and dout_ready are both 1.
REQ-023 Exactly one dout_valid assertion SHALL occur per req_a rise/fall cycle; no duplicate words.
REQ-024 dout SHALL change only on a capture edge in IDLE.
REQ-025 req_s falling while in HOLD SHALL set proto_err=1; the FSM stays in HOLD, the word remains deliverable, and it then proceeds to ACK and returns to IDLE on the next edge because req_s=0.
REQ-026 proto_err SHALL clear only on reset.
REQ-027 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, all synchronizer flops=0, ack_b=0, dout_valid=0, dout=0, proto_err=0, busy=0.
REQ-029 Reset deassertion SHALL be synchronized externally; the block samples rst_n only as an asynchronous clear.
REQ-030 Reset mid-transfer SHALL abandon the word and drop ack_b. If req_a is still high after release, the word is recaptured; the system requires the source to be reset together.

Structure
REQ-031 Package hdshk_pkg SHALL hold the state enum (IDLE, HOLD, ACK) and the default DW and SYNC_STAGES constants.
REQ-032 The synchronizer SHALL be a sub-module, hdshk_bit_sync (parameter STAGES, async active-low reset), reusable by the source side for ack_b.

Verification
REQ-033 Basic: data_a=8'hA5, req_a rises, dout_ready=1 -> dout=8'hA5, dout_valid high for 1 cycle, ack_b rises the same edge valid falls; req_a falls -> ack_b=0 SYNC_STAGES+1 edges later; busy=0.
REQ-034 Backpressure: dout_ready=0 for 10 cycles after capture of 8'h3C -> dout_valid held and dout=8'h3C stable, ack_b=0 throughout; dout_ready=1 -> ack_b=1 next edge.
REQ-035 Back-to-back: 4 words 8'h01..8'h04 with full 4-phase cycles and random clk ratios (source 0.3x-3x clk_b) -> 4 valid transfers in order, no duplicates or losses.
REQ-036 Protocol error: req_a dropped while in HOLD -> proto_err=1 and stays 1; word delivered; FSM returns to IDLE.
REQ-037 Reset: rst_n pulsed low in HOLD and again in ACK -> all outputs 0 immediately, without a clock edge.
REQ-038 Latency check at SYNC_STAGES=3: req_a rise -> dout_valid after exactly 4 edges.
